ppt_controller: RTL and testbench
=================================

Name: ppt_controller

Overview:
- PPT firing sequencer. It consumes the configuration fields from the I2C register map (clk_div, period, width, count, run_ppt).
- It drives the thruster trigger pulse and returns count_done/done to the register map.
- A prescaled tick base times `count` firings of `width` ticks high within a `period`-tick frame.

Parameters:
- DIV_W, 5, width of clk_div
- CNT_W, 16, width of period/width/count/count_done
- PRESC_W, 32, prescaler counter width; must be >= 2^DIV_W

Ports:
- clk  input  1  system clock (32.768 kHz oscillator domain)
- rst  input  1  synchronous, active-high reset
- clk_div  input  DIV_W  tick period = 2^(clk_div+1) clk cycles
- period  input  CNT_W  firing frame length in ticks
- width  input  CNT_W  pulse high time in ticks
- count  input  CNT_W  number of firings requested
- run_ppt  input  1  run request from register map (level; start on rising edge)
- pulse_out  output  1  thruster trigger, registered
- busy  output  1  high while a sequence is active
- count_done  output  CNT_W  completed firings, registered
- done  output  1  sequence completed normally

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, pulse_out=0, busy=0, count_done=0, done=0, prescaler=0, tick_cnt=0, run_q=0. Reset overrides every other event.
- run_q registers run_ppt each cycle; start = run_ppt & ~run_q.
- Shadow registers latch clk_div/period/width/count on start. Register writes during a run have no effect until the next start.
- eff_width = (width >= period) ? period-1 : width.
- States:
  - IDLE: pulse_out=0, busy=0.
    - On start with count==0, period==0 or eff_width==0: go to DONE; count_done=0, done=1.
    - On any other start: go to HIGH; count_done=0, done=0, prescaler=0, tick_cnt=0, pulse_out=1, busy=1. pulse_out rises on the cycle after start is sampled (1-cycle latency).
  - HIGH: pulse_out=1.
    - Prescaler counts 0..2^(clk_div+1)-1, then wraps to 0.
    - tick = 1 on the wrap cycle. Each tick increments tick_cnt.
    - When a tick makes tick_cnt reach eff_width: go to LOW, pulse_out=0.
  - LOW: pulse_out=0.
    - On a tick with tick_cnt==period-1, increment count_done.
    - If the new count_done==count: go to DONE; done=1, busy=0.
    - Otherwise go to HIGH with tick_cnt=0, pulse_out=1.
  - DONE: done=1, busy=0, pulse_out=0. When run_ppt=0, go to IDLE; done and count_done hold until the next start.
- Abort: run_ppt=0 in HIGH or LOW.
  - Next state IDLE; pulse_out=0, busy=0, done=0; count_done holds its value.
  - Abort has priority over a same-cycle period end, so count_done is not incremented on that cycle.
- Exact timing:
  - Pulse high time = eff_width*2^(clk_div+1) cycles.
  - Frame = period*2^(clk_div+1) cycles.
  - done asserts at cycle start+1+count*frame.
- Width rules: the prescaler compare uses a 2^(clk_div+1)-1 terminal value in PRESC_W bits, so clk_div=31 gives terminal 2^32-1. tick_cnt and count_done never wrap, because count bounds them.
- A start pulse while busy cannot occur, since run_ppt must fall first. run_ppt held high after DONE does not restart the sequence.

Decomposition:
- Package ppt_pkg: state enum (IDLE, HIGH, LOW, DONE), DIV_W/CNT_W/PRESC_W constants, and a function presc_terminal(clk_div).
- Sub-module ppt_prescaler:
  - Inputs: clk, rst, clear, enable, clk_div.
  - Output: single-cycle tick.
  - Behaviour: clear zeroes the count. Instantiated once.

Test Plan:
- Reset mid-run (rst during HIGH) -> next cycle pulse_out=0, busy=0, count_done=0, done=0, state IDLE.
- clk_div=0, period=4, width=1, count=3, run rising at cycle 0 -> pulse_out high in cycles 1-2, 9-10 and 17-18, low otherwise; count_done steps 1,2,3; done=1 at cycle 25.
- width=10, period=4, clk_div=0, count=1 -> eff_width=3; pulse high 6 cycles, low 2; done after 8 cycles.
- count=0 (or period=0) and run rising -> done=1 next cycle, pulse_out never high, count_done=0.
- Abort: config as the second scenario, drop run_ppt at cycle 12 -> pulse_out=0, done=0, count_done=1 held. Raising run again restarts with count_done=0.
- Shadow and re-arm check: change period mid-run -> the firing pattern is unchanged. Hold run_ppt high after done -> no restart. Toggle run 0->1 -> the new sequence uses the new period.

Source files
------------

// File: rtl/ppt_pkg.sv
// Shared types and constants for the PPT firing sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppt_pkg;

    localparam int PPT_DIV_W   = 5;
    localparam int PPT_CNT_W   = 16;
    localparam int PPT_PRESC_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } ppt_state_t;

    // Terminal count of the prescaler: 2^(clk_div+1)-1. Computed in 64 bits
    // so clk_div=31 yields 2^32-1 without overflow; callers truncate to
    // their counter width.
    function automatic logic [63:0] presc_terminal(input int unsigned clk_div);
        logic [63:0] one;
        one = 64'd1;
        return (one << (clk_div + 32'd1)) - 64'd1;
    endfunction

endpackage

// File: rtl/ppt_prescaler.sv
// Tick generator: divides clk by 2^(clk_div+1), one-cycle tick on each wrap.
// Latency: tick is combinational from the registered count (asserted on the wrap cycle).
// Backpressure: none; enable freezes the count, clear zeroes it.
module ppt_prescaler
    import ppt_pkg::*;
#(
    parameter int DIV_W   = PPT_DIV_W,
    parameter int PRESC_W = PPT_PRESC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick
);

    logic [PRESC_W-1:0] cnt;
    logic [PRESC_W-1:0] terminal;
    logic               at_term;

    assign terminal = PRESC_W'(presc_terminal(32'(clk_div)));
    assign at_term  = (cnt == terminal);
    assign tick     = enable && at_term;

    // Free-running modulo counter, held while disabled.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (at_term) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/ppt_controller.sv
// PPT firing sequencer: count pulses of width ticks inside period-tick frames.
// Latency: pulse_out rises one cycle after the run_ppt rising edge is sampled.
// Backpressure: none; run_ppt falling mid-sequence aborts to IDLE.
module ppt_controller
    import ppt_pkg::*;
#(
    parameter int DIV_W   = PPT_DIV_W,
    parameter int CNT_W   = PPT_CNT_W,
    parameter int PRESC_W = PPT_PRESC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] count,
    input  logic             run_ppt,
    output logic             pulse_out,
    output logic             busy,
    output logic [CNT_W-1:0] count_done,
    output logic             done
);

    ppt_state_t       state, state_n;
    logic             run_q;
    logic             start;
    logic             tick;
    logic             presc_clear;
    logic             presc_en;
    logic             latch;

    // Configuration captured at start; register-map writes mid-run are ignored.
    logic [DIV_W-1:0] clk_div_s;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] eff_width_s;
    logic [CNT_W-1:0] count_s;

    logic [CNT_W-1:0] eff_width_in;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_n;
    logic [CNT_W-1:0] count_done_n;
    logic             done_n;
    logic             pulse_n;
    logic             busy_n;

    assign start    = run_ppt && !run_q;
    assign presc_en = (state == HIGH) || (state == LOW);

    // A pulse as wide as the frame would leave no low time, so clamp it.
    assign eff_width_in = (width >= period) ? (period - CNT_W'(1)) : width;

    ppt_prescaler #(
        .DIV_W   (DIV_W),
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .rst     (rst),
        .clear   (presc_clear),
        .enable  (presc_en),
        .clk_div (clk_div_s),
        .tick    (tick)
    );

    // Next-state and datapath update; abort is checked before any tick work.
    always_comb begin
        state_n      = state;
        tick_cnt_n   = tick_cnt;
        count_done_n = count_done;
        done_n       = done;
        presc_clear  = 1'b0;
        latch        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    latch        = 1'b1;
                    count_done_n = '0;
                    if ((count == '0) || (period == '0) || (eff_width_in == '0)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n     = HIGH;
                        done_n      = 1'b0;
                        tick_cnt_n  = '0;
                        presc_clear = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!run_ppt) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end else if (tick) begin
                    tick_cnt_n = tick_cnt + CNT_W'(1);
                    if ((tick_cnt + CNT_W'(1)) == eff_width_s) begin
                        state_n = LOW;
                    end
                end
            end
            LOW: begin
                if (!run_ppt) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end else if (tick) begin
                    if (tick_cnt == (period_s - CNT_W'(1))) begin
                        count_done_n = count_done + CNT_W'(1);
                        if ((count_done + CNT_W'(1)) == count_s) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n    = HIGH;
                            tick_cnt_n = '0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (!run_ppt) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        pulse_n = (state_n == HIGH);
        busy_n  = (state_n == HIGH) || (state_n == LOW);
    end

    // State, outputs and shadow configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            run_q       <= 1'b0;
            tick_cnt    <= '0;
            count_done  <= '0;
            done        <= 1'b0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            clk_div_s   <= '0;
            period_s    <= '0;
            eff_width_s <= '0;
            count_s     <= '0;
        end else begin
            state      <= state_n;
            run_q      <= run_ppt;
            tick_cnt   <= tick_cnt_n;
            count_done <= count_done_n;
            done       <= done_n;
            pulse_out  <= pulse_n;
            busy       <= busy_n;
            if (latch) begin
                clk_div_s   <= clk_div;
                period_s    <= period;
                eff_width_s <= eff_width_in;
                count_s     <= count;
            end
        end
    end

endmodule

// File: tb/tb_ppt_controller.sv
// Self-checking bench for ppt_controller.
// Directed table of configurations plus hand-written multi-cycle sequences.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_ppt_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  clk_div;
    logic [15:0] period;
    logic [15:0] width;
    logic [15:0] count;
    logic        run_ppt;
    logic        pulse_out;
    logic        busy;
    logic [15:0] count_done;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    ppt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .period     (period),
        .width      (width),
        .count      (count),
        .run_ppt    (run_ppt),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .count_done (count_done),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cd;
        logic [15:0] per;
        logic [15:0] wid;
        logic [15:0] cnt;
        int          exp_done_cyc;
        int          exp_high;
        int          exp_cd;
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [4:0] cd, input logic [15:0] per,
                       input logic [15:0] wid, input logic [15:0] cnt);
        clk_div = cd;
        period  = per;
        width   = wid;
        count   = cnt;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        run_ppt = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Raises run_ppt and counts cycles until done; cycle 1 is the first
    // sample after the edge that sees the rising run_ppt.
    task automatic run_until_done(input int limit, output int cyc, output int highs);
        bit got;
        got     = 1'b0;
        highs   = 0;
        cyc     = -1;
        run_ppt = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (pulse_out) highs++;
            if (done) begin
                cyc = k;
                got = 1'b1;
                break;
            end
        end
        if (!got) $display("FAIL timeout: done not seen within %0d cycles", limit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int highs;
        int exp_cd;

        tbl[0] = '{5'd0, 16'd4, 16'd1,  16'd3, 25, 6,  3};
        tbl[1] = '{5'd0, 16'd4, 16'd10, 16'd1, 9,  6,  1};
        tbl[2] = '{5'd0, 16'd4, 16'd1,  16'd0, 1,  0,  0};
        tbl[3] = '{5'd0, 16'd0, 16'd1,  16'd2, 1,  0,  0};
        tbl[4] = '{5'd1, 16'd3, 16'd2,  16'd2, 25, 16, 2};
        tbl[5] = '{5'd0, 16'd1, 16'd1,  16'd1, 1,  0,  0};
        tbl[6] = '{5'd2, 16'd2, 16'd1,  16'd1, 17, 8,  1};

        cfg(5'd0, 16'd4, 16'd1, 16'd3);
        do_reset();
        check("reset pulse_out", int'(pulse_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset count_done", int'(count_done), 0);

        // Table-driven configurations.
        for (int i = 0; i < 7; i++) begin
            cfg(tbl[i].cd, tbl[i].per, tbl[i].wid, tbl[i].cnt);
            do_reset();
            run_until_done(1000, cyc, highs);
            check($sformatf("vec%0d done cycle", i), cyc, tbl[i].exp_done_cyc);
            check($sformatf("vec%0d high cycles", i), highs, tbl[i].exp_high);
            check($sformatf("vec%0d count_done", i), int'(count_done), tbl[i].exp_cd);
            check($sformatf("vec%0d busy at done", i), int'(busy), 0);
            check($sformatf("vec%0d pulse at done", i), int'(pulse_out), 0);
        end

        // Exact cycle-by-cycle pattern: clk_div=0, period=4, width=1, count=3.
        cfg(5'd0, 16'd4, 16'd1, 16'd3);
        do_reset();
        run_ppt = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            step();
            exp_cd = (k < 9) ? 0 : (k < 17) ? 1 : (k < 25) ? 2 : 3;
            check($sformatf("pattern pulse c%0d", k), int'(pulse_out),
                  (k == 1 || k == 2 || k == 9 || k == 10 || k == 17 || k == 18) ? 1 : 0);
            check($sformatf("pattern count_done c%0d", k), int'(count_done), exp_cd);
            check($sformatf("pattern busy c%0d", k), int'(busy), (k <= 24) ? 1 : 0);
            check($sformatf("pattern done c%0d", k), int'(done), (k >= 25) ? 1 : 0);
        end

        // Reset while in HIGH.
        do_reset();
        run_ppt = 1'b1;
        step();
        step();
        check("pre-reset pulse high", int'(pulse_out), 1);
        rst = 1'b1;
        step();
        check("midrun reset pulse_out", int'(pulse_out), 0);
        check("midrun reset busy", int'(busy), 0);
        check("midrun reset count_done", int'(count_done), 0);
        check("midrun reset done", int'(done), 0);
        rst     = 1'b0;
        run_ppt = 1'b0;
        step();

        // Abort at cycle 12 (LOW of the second frame).
        do_reset();
        run_ppt = 1'b1;
        repeat (11) step();
        run_ppt = 1'b0;
        step();
        check("abort pulse_out", int'(pulse_out), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort count_done", int'(count_done), 1);
        repeat (3) step();
        check("abort count_done held", int'(count_done), 1);
        check("abort stays low", int'(pulse_out), 0);
        run_ppt = 1'b1;
        step();
        check("restart count_done cleared", int'(count_done), 0);
        check("restart pulse_out", int'(pulse_out), 1);
        check("restart busy", int'(busy), 1);
        run_ppt = 1'b0;
        step();

        // Abort on the very edge that would end the first frame.
        do_reset();
        run_ppt = 1'b1;
        repeat (8) step();
        run_ppt = 1'b0;
        step();
        check("abort priority count_done", int'(count_done), 0);
        check("abort priority busy", int'(busy), 0);
        check("abort priority pulse_out", int'(pulse_out), 0);

        // Shadow registers: period change mid-run has no effect.
        cfg(5'd0, 16'd4, 16'd1, 16'd2);
        do_reset();
        run_ppt = 1'b1;
        cyc     = -1;
        highs   = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (k == 3) period = 16'd8;
            if (pulse_out) highs++;
            if (done) begin
                cyc = k;
                break;
            end
        end
        check("shadow done cycle", cyc, 17);
        check("shadow high cycles", highs, 4);
        check("shadow count_done", int'(count_done), 2);

        // run_ppt held high after done: no restart.
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (pulse_out || busy) highs++;
        end
        check("hold run no restart activity", highs, 0);
        check("hold run done stays", int'(done), 1);
        run_ppt = 1'b0;
        step();
        check("after run drop done holds", int'(done), 1);
        check("after run drop count_done holds", int'(count_done), 2);
        step();

        // Re-arm picks up the new period of 8.
        run_until_done(1000, cyc, highs);
        check("rearm done cycle", cyc, 33);
        check("rearm high cycles", highs, 4);
        check("rearm count_done", int'(count_done), 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
